// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pipeline hazard unit with per-GPR scoreboard for long-latency ops
//
// Purpose:
//   Generates execute-stage forwarding selects plus the stall and flush controls
//   for a 5-stage core. It also keeps a per-register pending scoreboard so that
//   variable-latency units (mul/div, cache-miss loads) can write back out of order.
//
// Ports:
//   clk, reset                       core clock, asynchronous active-high reset
//   rs1/rs2/rd_decode, long_decode   decode-stage indices and long-op flag
//   rs1/rs2/rd_execute               execute-stage indices
//   load_on_execute, long_issue      normal load in execute / long op issued this cycle
//   complete_valid, rd_complete      long-latency writeback strobe and destination
//   rd_memory, rd_writeback          destinations in memory / writeback
//   write_gpr_memory/_writeback      those stages write a GPR
//   branch_taken                     branch resolved taken in execute
//   forward_rs1, forward_rs2         0 none, 1 from memory, 2 from writeback
//   stall_fetch, stall_decode        hold the front end
//   flush_decode, flush_execute      squash decode / insert bubble into execute
//   inflight_count, pending          outstanding long ops and scoreboard bits
//
// Optional feature macro: HAZARD_SCOREBOARD_STATS_EN adds stall_cycles,
// flush_events and full_stall_cycles 32-bit event counters.

module hazard_scoreboard #(
    parameter int GPR_COUNT    = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int FWD_SRC_BITS = 2,
    localparam int RW = $clog2(GPR_COUNT),
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [RW-1:0]           rs1_decode,
    input  logic [RW-1:0]           rs2_decode,
    input  logic [RW-1:0]           rd_decode,
    input  logic                    long_decode,
    input  logic [RW-1:0]           rs1_execute,
    input  logic [RW-1:0]           rs2_execute,
    input  logic [RW-1:0]           rd_execute,
    input  logic                    load_on_execute,
    input  logic                    long_issue,
    input  logic                    complete_valid,
    input  logic [RW-1:0]           rd_complete,
    input  logic [RW-1:0]           rd_memory,
    input  logic [RW-1:0]           rd_writeback,
    input  logic                    write_gpr_memory,
    input  logic                    write_gpr_writeback,
    input  logic                    branch_taken,
    output logic [FWD_SRC_BITS-1:0] forward_rs1,
    output logic [FWD_SRC_BITS-1:0] forward_rs2,
    output logic                    stall_fetch,
    output logic                    stall_decode,
    output logic                    flush_decode,
    output logic                    flush_execute,
    output logic [CW-1:0]           inflight_count,
    output logic [GPR_COUNT-1:0]    pending
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             flush_events,
    output logic [31:0]             full_stall_cycles
`endif
);

    localparam logic [FWD_SRC_BITS-1:0] NO_FORWARDING  = FWD_SRC_BITS'(0);
    localparam logic [FWD_SRC_BITS-1:0] FROM_MEMORY    = FWD_SRC_BITS'(1);
    localparam logic [FWD_SRC_BITS-1:0] FROM_WRITEBACK = FWD_SRC_BITS'(2);
    localparam logic [CW-1:0]           MAX_COUNT      = CW'(MAX_INFLIGHT);

    // Memory stage is younger than writeback, so it takes priority.
    function automatic logic [FWD_SRC_BITS-1:0] fwd_sel(
        input logic [RW-1:0] rs,
        input logic [RW-1:0] rd_mem,
        input logic          wr_mem,
        input logic [RW-1:0] rd_wb,
        input logic          wr_wb
    );
        if (rs == '0)
            return NO_FORWARDING;
        else if (wr_mem && rs == rd_mem)
            return FROM_MEMORY;
        else if (wr_wb && rs == rd_wb)
            return FROM_WRITEBACK;
        else
            return NO_FORWARDING;
    endfunction

    logic load_stall;
    logic raw_stall;
    logic waw_stall;
    logic full_stall;
    logic stall;

    always_comb begin
        forward_rs1 = fwd_sel(rs1_execute, rd_memory, write_gpr_memory,
                              rd_writeback, write_gpr_writeback);
        forward_rs2 = fwd_sel(rs2_execute, rd_memory, write_gpr_memory,
                              rd_writeback, write_gpr_writeback);
    end

    always_comb begin
        load_stall = load_on_execute && (rd_execute != '0) &&
                     ((rs1_decode == rd_execute) || (rs2_decode == rd_execute));
        // Decode reads the registered scoreboard only: a completion clears the
        // bit at the edge, so there is no same-cycle bypass.
        raw_stall  = pending[rs1_decode] || pending[rs2_decode];
        waw_stall  = long_decode && pending[rd_decode];
        full_stall = long_decode && (inflight_count == MAX_COUNT);
        stall      = load_stall || raw_stall || waw_stall || full_stall;

        stall_fetch   = stall;
        stall_decode  = stall;
        flush_decode  = branch_taken;
        flush_execute = stall || branch_taken;
    end

    logic [GPR_COUNT-1:0] pending_next;
    logic [CW-1:0]        count_next;

    always_comb begin
        pending_next = pending;
        // Clear before set so an issue to the register being completed wins.
        if (complete_valid)
            pending_next[rd_complete] = 1'b0;
        if (long_issue && rd_execute != '0)
            pending_next[rd_execute] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // An issue to x0 still occupies a unit, so the count tracks every issue,
    // not only those that touch the scoreboard.
    always_comb begin
        count_next = inflight_count;
        if (long_issue && !complete_valid) begin
            if (inflight_count != MAX_COUNT)
                count_next = inflight_count + CW'(1);
        end else if (complete_valid && !long_issue) begin
            if (inflight_count != '0)
                count_next = inflight_count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending        <= '0;
            inflight_count <= '0;
        end else begin
            pending        <= pending_next;
            inflight_count <= count_next;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(complete_valid && !long_issue && inflight_count == '0));
            assert (!(long_issue && !complete_valid && inflight_count == MAX_COUNT));
        end
    end
`endif

`ifdef HAZARD_SCOREBOARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles      <= '0;
            flush_events      <= '0;
            full_stall_cycles <= '0;
        end else begin
            if (stall)
                stall_cycles <= stall_cycles + 32'd1;
            if (branch_taken)
                flush_events <= flush_events + 32'd1;
            if (full_stall)
                full_stall_cycles <= full_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized bench for hazard_scoreboard

module tb_hazard_scoreboard;

    localparam int GPR = 32;
    localparam int MAXI = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_decode, rs2_decode, rd_decode;
    logic       long_decode;
    logic [4:0] rs1_execute, rs2_execute, rd_execute;
    logic       load_on_execute, long_issue, complete_valid;
    logic [4:0] rd_complete, rd_memory, rd_writeback;
    logic       write_gpr_memory, write_gpr_writeback, branch_taken;
    logic [1:0] forward_rs1, forward_rs2;
    logic       stall_fetch, stall_decode, flush_decode, flush_execute;
    logic [2:0] inflight_count;
    logic [31:0] pending;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles, flush_events, full_stall_cycles;
    int unsigned m_stall_cnt, m_flush_cnt, m_full_cnt;
`endif

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_decode(rd_decode),
        .long_decode(long_decode),
        .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
        .load_on_execute(load_on_execute), .long_issue(long_issue),
        .complete_valid(complete_valid), .rd_complete(rd_complete),
        .rd_memory(rd_memory), .rd_writeback(rd_writeback),
        .write_gpr_memory(write_gpr_memory), .write_gpr_writeback(write_gpr_writeback),
        .branch_taken(branch_taken),
        .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .flush_decode(flush_decode), .flush_execute(flush_execute),
        .inflight_count(inflight_count), .pending(pending)
`ifdef HAZARD_SCOREBOARD_STATS_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events),
        .full_stall_cycles(full_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the set of outstanding long ops (by destination) and
    // which registers are awaiting writeback.
    int m_q[$];
    bit m_pend [GPR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (rs == 0) return 2'd0;
        if (write_gpr_memory && rs == rd_memory) return 2'd1;
        if (write_gpr_writeback && rs == rd_writeback) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit m_full();
        return long_decode && (m_q.size() == MAXI);
    endfunction

    function automatic bit m_stall();
        bit ld, raw, waw;
        ld  = load_on_execute && rd_execute != 0 &&
              (rs1_decode == rd_execute || rs2_decode == rd_execute);
        raw = m_pend[rs1_decode] || m_pend[rs2_decode];
        waw = long_decode && m_pend[rd_decode];
        return ld || raw || waw || m_full();
    endfunction

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < GPR; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic idle();
        rs1_decode = 0; rs2_decode = 0; rd_decode = 0; long_decode = 0;
        rs1_execute = 0; rs2_execute = 0; rd_execute = 0;
        load_on_execute = 0; long_issue = 0; complete_valid = 0; rd_complete = 0;
        rd_memory = 0; rd_writeback = 0; write_gpr_memory = 0; write_gpr_writeback = 0;
        branch_taken = 0;
    endtask

    // Compare every output with the model for the current inputs.
    task automatic settle();
        bit s;
        #1;
        s = m_stall();
        chk("forward_rs1", 64'(forward_rs1), 64'(m_fwd(rs1_execute)));
        chk("forward_rs2", 64'(forward_rs2), 64'(m_fwd(rs2_execute)));
        chk("stall_fetch", 64'(stall_fetch), 64'(s));
        chk("stall_decode", 64'(stall_decode), 64'(s));
        chk("flush_decode", 64'(flush_decode), 64'(branch_taken));
        chk("flush_execute", 64'(flush_execute), 64'(s || branch_taken));
        chk("inflight_count", 64'(inflight_count), 64'(m_q.size()));
        chk("pending", 64'(pending), 64'(m_pend_vec()));
`ifdef HAZARD_SCOREBOARD_STATS_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall_cnt));
        chk("flush_events", 64'(flush_events), 64'(m_flush_cnt));
        chk("full_stall_cycles", 64'(full_stall_cycles), 64'(m_full_cnt));
`endif
    endtask

    task automatic tick();
        int idx;
`ifdef HAZARD_SCOREBOARD_STATS_EN
        bit s, f;
        s = m_stall();
        f = m_full();
`endif
        @(posedge clk);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        if (s) m_stall_cnt++;
        if (branch_taken) m_flush_cnt++;
        if (f) m_full_cnt++;
`endif
        if (complete_valid) begin
            idx = -1;
            foreach (m_q[i]) if (idx < 0 && m_q[i] == int'(rd_complete)) idx = i;
            if (idx >= 0) m_q.delete(idx);
            m_pend[rd_complete] = 0;
        end
        if (long_issue) begin
            m_q.push_back(int'(rd_execute));
            if (rd_execute != 0) m_pend[rd_execute] = 1;
        end
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        foreach (m_pend[i]) m_pend[i] = 0;
`ifdef HAZARD_SCOREBOARD_STATS_EN
        m_stall_cnt = 0; m_flush_cnt = 0; m_full_cnt = 0;
`endif
    endtask

    initial begin
        idle();
        model_reset();
        reset = 1'b1;
        #12;
        // Reset state with idle inputs.
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_count", 64'(inflight_count), 64'd0);
        chk("rst_ctrl", 64'({stall_fetch, stall_decode, flush_decode, flush_execute}), 64'd0);
        chk("rst_fwd", 64'({forward_rs1, forward_rs2}), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        settle(); tick();

        // Forwarding priority.
        rs2_execute = 5; rd_memory = 7; rd_writeback = 5; write_gpr_writeback = 1;
        settle(); chk("fwd_wb", 64'(forward_rs2), 64'd2); tick();
        rd_memory = 5; write_gpr_memory = 1;
        settle(); chk("fwd_mem", 64'(forward_rs2), 64'd1); tick();
        rs2_execute = 0;
        settle(); chk("fwd_x0", 64'(forward_rs2), 64'd0); tick();
        idle();

        // RAW on a long op: stall until its completion is registered.
        long_issue = 1; rd_execute = 9;
        settle(); tick();
        long_issue = 0; rd_execute = 0; rs1_decode = 9;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("raw_hold", 64'({stall_fetch, stall_decode, flush_execute}), 64'h7);
            chk("raw_count", 64'(inflight_count), 64'd1);
            tick();
        end
        complete_valid = 1; rd_complete = 9;
        settle(); chk("raw_no_bypass", 64'(stall_fetch), 64'd1); tick();
        complete_valid = 0;
        settle();
        chk("raw_release", 64'({stall_fetch, stall_decode, flush_execute}), 64'd0);
        chk("raw_count0", 64'(inflight_count), 64'd0);
        tick();
        idle();

        // Fill all units, then a long op in decode must wait for a free slot.
        for (int r = 1; r <= 4; r++) begin
            long_issue = 1; rd_execute = 5'(r);
            settle(); tick();
        end
        idle();
        long_decode = 1; rd_decode = 10;
        settle(); chk("full_stall", 64'(stall_decode), 64'd1); tick();
        complete_valid = 1; rd_complete = 2;
        settle(); chk("full_hold", 64'(stall_decode), 64'd1); tick();
        complete_valid = 0;
        settle();
        chk("full_count3", 64'(inflight_count), 64'd3);
        chk("full_release", 64'(stall_decode), 64'd0);
        tick();
        idle();

        // Simultaneous issue and complete.
        complete_valid = 1; rd_complete = 3; long_issue = 1; rd_execute = 3;
        settle(); tick();
        idle(); settle();
        chk("same_reg_set_wins", 64'(pending[3]), 64'd1);
        chk("same_reg_count", 64'(inflight_count), 64'd3);
        complete_valid = 1; rd_complete = 3; long_issue = 1; rd_execute = 4;
        tick();
        idle(); settle();
        chk("diff_reg", 64'({pending[4], pending[3]}), 64'b10);
        tick();

        // Drain remaining ops.
        while (m_q.size() > 0) begin
            complete_valid = 1; rd_complete = 5'(m_q[0]);
            settle(); tick();
        end
        idle();

        // Load-use stall together with a taken branch.
        load_on_execute = 1; rd_execute = 6; rs1_decode = 6; branch_taken = 1;
        settle();
        chk("load_br_ctrl", 64'({flush_decode, flush_execute, stall_fetch}), 64'h7);
        tick();
        rd_execute = 0;
        settle();
        chk("load_x0_nostall", 64'(stall_fetch), 64'd0);
        chk("load_x0_flush", 64'(flush_execute), 64'd1);
        tick();
        idle();

        // Asynchronous reset while ops are outstanding.
        long_issue = 1; rd_execute = 7;
        settle(); tick();
        idle();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pending", 64'(pending), 64'd0);
        chk("async_rst_count", 64'(inflight_count), 64'd0);
        model_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic with legal issue/complete sequencing.
        for (int n = 0; n < 400; n++) begin
            rs1_decode          = 5'($urandom_range(0, 7));
            rs2_decode          = 5'($urandom_range(0, 7));
            rd_decode           = 5'($urandom_range(0, 7));
            long_decode         = ($urandom_range(0, 2) == 0);
            rs1_execute         = 5'($urandom_range(0, 7));
            rs2_execute         = 5'($urandom_range(0, 7));
            rd_execute          = 5'($urandom_range(0, 7));
            rd_memory           = 5'($urandom_range(0, 7));
            rd_writeback        = 5'($urandom_range(0, 7));
            write_gpr_memory    = 1'($urandom_range(0, 1));
            write_gpr_writeback = 1'($urandom_range(0, 1));
            load_on_execute     = ($urandom_range(0, 3) == 0);
            branch_taken        = ($urandom_range(0, 5) == 0);
            complete_valid      = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
            rd_complete         = complete_valid ?
                                  5'(m_q[$urandom_range(0, m_q.size() - 1)]) : 5'd0;
            long_issue          = (m_q.size() < MAXI) && ($urandom_range(0, 2) == 0);
            settle();
            tick();
        end
        idle();
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard unit: same forwarding, load-use stall and branch-flush duties, plus a per-GPR scoreboard for variable-latency units (multi-cycle mul/div, cache-miss loads) that write back out of order.
- Sits beside the 5-stage core datapath.
- Consumes register indices from decode/execute/memory/writeback plus issue/complete strobes from long-latency units.
- Drives forwarding selects, stall and flush controls.

Parameters:
- GPR_COUNT, 32, number of architectural GPRs; index width RW = $clog2(GPR_COUNT); register 0 is hardwired zero.
- MAX_INFLIGHT, 4, maximum simultaneously outstanding long-latency ops; count width CW = $clog2(MAX_INFLIGHT+1).
- FWD_SRC_BITS, 2, width of forwarding select encoding (NO_FORWARDING=0, FROM_MEMORY=1, FROM_WRITEBACK=2).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- rs1_decode, rs2_decode, rd_decode  in  RW  source/destination indices in decode.
- long_decode  in  1  decode instruction is a long-latency op.
- rs1_execute, rs2_execute, rd_execute  in  RW  indices in execute.
- load_on_execute  in  1  execute holds a normal (single-cycle-memory) load.
- long_issue  in  1  execute issues a long-latency op writing rd_execute this cycle.
- complete_valid  in  1  a long-latency unit writes back this cycle.
- rd_complete  in  RW  destination of that writeback.
- rd_memory, rd_writeback  in  RW  destinations in memory/writeback.
- write_gpr_memory, write_gpr_writeback  in  1  those stages write a GPR.
- branch_taken  in  1  branch resolved taken in execute.
- forward_rs1, forward_rs2  out  FWD_SRC_BITS  forwarding selects for execute.
- stall_fetch, stall_decode, flush_decode, flush_execute  out  1  pipeline controls.
- inflight_count  out  CW  outstanding long ops.
- pending  out  GPR_COUNT  scoreboard bit vector.

Behaviour:
- State: pending[GPR_COUNT-1:0], inflight_count[CW-1:0].
- Reset: both cleared, asynchronously. All combinational outputs are then 0 given idle inputs.
- Forwarding (combinational), per source rsN_execute:
  - 0 if rsN_execute==0.
  - Else FROM_MEMORY if write_gpr_memory and rsN_execute==rd_memory.
  - Else FROM_WRITEBACK if write_gpr_writeback and rsN_execute==rd_writeback.
  - Else NO_FORWARDING.
  - rs2 compares against its own stage destinations, identical to rs1.
- load_stall = load_on_execute & rd_execute!=0 & (rs1_decode==rd_execute | rs2_decode==rd_execute).
- raw_stall = pending[rs1_decode] | pending[rs2_decode]. Index 0 is never pending.
- waw_stall = long_decode & pending[rd_decode].
- full_stall = long_decode & (inflight_count==MAX_INFLIGHT).
- stall = load_stall | raw_stall | waw_stall | full_stall.
- Pipeline controls:
  - stall_fetch = stall_decode = stall.
  - flush_decode = branch_taken.
  - flush_execute = stall | branch_taken.
- Issue accepted on a clk edge when long_issue & rd_execute!=0. pending[rd_execute] is set. inflight_count increments.
  - long_issue with rd_execute==0: no scoreboard change, count still increments (op occupies a unit). A matching complete with rd_complete==0 decrements.
- Completion on a clk edge when complete_valid: pending[rd_complete] cleared, inflight_count decrements.
  - Decode sees the cleared bit the following cycle. There is no same-cycle bypass from complete.
- Simultaneous issue and complete:
  - Different registers: both applied, count unchanged.
  - Same register: set wins, count unchanged.
- Complete with count==0 is illegal. Count saturates at 0, and an assertion fires in simulation.
- Issue with count==MAX_INFLIGHT cannot occur because full_stall blocks it. Count saturates at MAX_INFLIGHT, and an assertion fires.
- branch_taken does not cancel already-issued long ops. Their completions still clear pending.
- Reset mid-operation clears the scoreboard immediately. Late completions after reset are ignored (count saturates at 0).

Optional Feature:
- Macro HAZARD_SCOREBOARD_STATS_EN.
- When defined, adds three 32-bit outputs, each cleared on reset and wrapping at 2^32:
  - stall_cycles: increments every cycle stall==1.
  - flush_events: increments every cycle branch_taken==1.
  - full_stall_cycles: increments when full_stall==1.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset with stimulus idle -> pending==0, inflight_count==0, all stall/flush outputs 0, forward selects 0.
- rs2_execute=5, rd_memory=7, rd_writeback=5, write_gpr_writeback=1 -> forward_rs2=2. Then rd_memory=5, write_gpr_memory=1 -> forward_rs2=1. With rs2_execute=0 -> 0.
- long_issue with rd_execute=9, then rs1_decode=9 -> stall_fetch/stall_decode/flush_execute=1 every cycle until complete_valid with rd_complete=9. All three drop the cycle after; inflight_count goes 1 then 0.
- Four issues to x1..x4, then long_decode=1 with rd_decode=10 -> full_stall. It holds until one complete arrives, after which count==3 and the stall releases.
- Same edge: complete rd=3 and issue rd=3 -> pending[3] stays 1, count unchanged. Same edge with issue rd=4 -> pending[3]=0, pending[4]=1.
- Load in execute with rd=6 and rs1_decode=6, plus branch_taken=1 -> flush_decode=1, flush_execute=1, stall=1. Repeat with rd_execute=0 -> no stall.
